// File: rtl/cavlc_pkg.sv
// Shared widths and FSM encoding for the CAVLC bitstream back end.
package cavlc_pkg;
    localparam int CAVLC_IN_W  = 128;
    localparam int CAVLC_LEN_W = 7;
    localparam int CAVLC_OUT_W = 32;
    localparam int CAVLC_BUF_W = CAVLC_IN_W + CAVLC_OUT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } packer_state_e;
endpackage

// File: rtl/cavlc_bit_align.sv
// Masks a len-bit LSB-aligned code and places its first bit at MSB offset pos
// of a BUF_W-wide accumulator image.
module cavlc_bit_align #(
    parameter int IN_W  = 128,
    parameter int LEN_W = 7,
    parameter int BUF_W = 160,
    parameter int POS_W = 8
) (
    input  logic [IN_W-1:0]  code,
    input  logic [LEN_W-1:0] len,
    input  logic [POS_W-1:0] pos,
    output logic [BUF_W-1:0] aligned
);
    logic [IN_W-1:0]  masked;
    logic [BUF_W-1:0] ext;
    logic [POS_W:0]   shamt;

    // pos + len never exceeds BUF_W, so shamt cannot underflow.
    always_comb begin
        masked  = code & ~({IN_W{1'b1}} << len);
        ext     = {{(BUF_W-IN_W){1'b0}}, masked};
        shamt   = (POS_W+1)'(BUF_W) - {1'b0, pos} - (POS_W+1)'(len);
        aligned = ext << shamt;
    end
endmodule

// File: rtl/cavlc_bit_packer.sv
// Packs variable-length CAVLC codes MSB-first into a 32-bit word stream,
// with back-pressure and a flush that zero-pads the final partial word.
module cavlc_bit_packer
    import cavlc_pkg::*;
#(
    parameter int IN_W  = CAVLC_IN_W,
    parameter int LEN_W = CAVLC_LEN_W,
    parameter int OUT_W = CAVLC_OUT_W,
    parameter int BUF_W = IN_W + OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cavlc_enc_valid,
    input  logic [IN_W-1:0]  cavlc_bitstream_code,
    input  logic [LEN_W-1:0] cavlc_bitstream_bit,
    output logic             packer_ready,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             word_valid,
    output logic [OUT_W-1:0] word_data,
    input  logic             word_ready,
    output logic [31:0]      total_bits
);
    localparam int FILL_W = 8;
    localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(OUT_W);

    packer_state_e     state, state_next;
    logic [FILL_W-1:0] fill, fill_pop;
    logic [BUF_W-1:0]  acc_buf, buf_pop, aligned;
    logic              pad_pending;
    logic              pop, accept, drain_last;

    assign word_valid = (fill >= WORD_BITS) || pad_pending;
    assign word_data  = acc_buf[BUF_W-1 -: OUT_W];

    assign pop        = word_valid && word_ready;
    assign fill_pop   = pop ? fill - WORD_BITS : fill;
    assign buf_pop    = pop ? acc_buf << OUT_W : acc_buf;
    assign accept     = cavlc_enc_valid && packer_ready;
    assign drain_last = (state == DRAIN) && (fill_pop < WORD_BITS);

    cavlc_bit_align #(
        .IN_W  (IN_W),
        .LEN_W (LEN_W),
        .BUF_W (BUF_W),
        .POS_W (FILL_W)
    ) u_align (
        .code    (cavlc_bitstream_code),
        .len     (cavlc_bitstream_bit),
        .pos     (fill_pop),
        .aligned (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (flush_req) state_next = DRAIN;
            DRAIN: if (drain_last) state_next = (fill_pop != '0) ? PAD : DONE;
            PAD:   if (pop) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        packer_ready = !rst && (state == IDLE) && (fill_pop < WORD_BITS);
        flush_done   = (state == DONE);
    end

    // In PAD the final partial word leaves in one pop, emptying the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill        <= '0;
            acc_buf     <= '0;
            pad_pending <= 1'b0;
            total_bits  <= '0;
        end else begin
            if (state == PAD && pop) begin
                fill        <= '0;
                acc_buf     <= '0;
                pad_pending <= 1'b0;
            end else begin
                fill    <= fill_pop + (accept ? FILL_W'(cavlc_bitstream_bit) : '0);
                acc_buf <= buf_pop | (accept ? aligned : '0);
                if (drain_last && fill_pop != '0)
                    pad_pending <= 1'b1;
            end
            if (accept)
                total_bits <= total_bits + 32'(cavlc_bitstream_bit);
        end
    end
endmodule
